// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants and small helpers for the timing generator
// and the pixel generators that use the same screen-origin arithmetic.
package vga_timing_gen_pkg;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned RGB_W = 12;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_TOTAL  = 800;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_TOTAL  = 525;

  // Visible window corners (inclusive) for the default 640x480 timing.
  localparam int unsigned H_VIS_START = DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned H_VIS_END   = H_VIS_START + DEF_H_ACTIVE - 1;
  localparam int unsigned V_VIS_START = DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned V_VIS_END   = V_VIS_START + DEF_V_ACTIVE - 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  // True when lo <= pos < hi_excl.
  function automatic logic in_span(cnt_t pos, cnt_t lo, cnt_t hi_excl);
    return (pos >= lo) && (pos < hi_excl);
  endfunction

endpackage

// File: rtl/vga_timing_gen_clk_en_div.sv
// Reusable strobe divider: one-clock enable pulse every CLK_DIV clocks.
module clk_en_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;

  // Divider wraps at CLK_DIV-1; the strobe is registered in that same clock.
  always_comb begin
    div_d    = div_q + 1'b1;
    pix_en_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d    = '0;
      pix_en_d = 1'b1;
    end
  end

  // Divider state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: pixel strobe, h/v counters, visible-window decode and
// a registered sync/colour stage that lags the counters by one pixel.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_TOTAL  = DEF_V_TOTAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RGB_W-1:0] pix_rgb,
  output logic             pix_en,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             frame_tick,
  output logic             hSync,
  output logic             vSync,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b
);

  localparam cnt_t H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam cnt_t V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam cnt_t H_SYNC_END = CNT_W'(H_SYNC);
  localparam cnt_t V_SYNC_END = CNT_W'(V_SYNC);
  localparam cnt_t H_VIS_LO   = CNT_W'(H_SYNC + H_BP);
  localparam cnt_t H_VIS_HI   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam cnt_t V_VIS_LO   = CNT_W'(V_SYNC + V_BP);
  localparam cnt_t V_VIS_HI   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  logic pix_en_w;
  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  rgb_t rgb_q, rgb_d;
  logic h_last, v_last, bright_w;

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en_w)
  );

  // Window and end-of-line/frame decode from the current counters.
  always_comb begin
    h_last   = (h_cnt_q == H_LAST);
    v_last   = (v_cnt_q == V_LAST);
    bright_w = in_span(h_cnt_q, H_VIS_LO, H_VIS_HI) &&
               in_span(v_cnt_q, V_VIS_LO, V_VIS_HI);
  end

  // Next counter values: advance one pixel per strobe, wrap line and frame.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en_w) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Output stage inputs: syncs and colour for the pixel currently addressed,
  // captured on the same strobe that moves the counters on.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pix_en_w) begin
      hsync_d = ~(h_cnt_q < H_SYNC_END);
      vsync_d = ~(v_cnt_q < V_SYNC_END);
      rgb_d   = bright_w ? pix_rgb : '0;
    end
  end

  // Counter and output registers, cleared asynchronously to idle sync levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign pix_en     = pix_en_w;
  assign hCount     = h_cnt_q;
  assign vCount     = v_cnt_q;
  assign bright     = bright_w;
  assign frame_tick = pix_en_w & h_last & v_last;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];

endmodule
